// File: rtl/bbc_cycle_sched.sv
// Per-cycle CPU clock and bus scheduler: generates the 65816 PHI2 from bbc_ck8 and
// chooses between a fast on-board RAM cycle and a BBC bus cycle aligned to BBC phi0.
`timescale 1ns/1ps
module bbc_cycle_sched #(
    parameter int SYNC_TIMEOUT = 12
) (
    input  logic bbc_ck8,
    input  logic resetb,
    input  logic bbc_ck2_phi0,
    input  logic fast_en,
    input  logic addr15,
    input  logic vda,
    input  logic vpa,
    input  logic vpb,
    output logic cpu_ck_phi2,
    output logic ram_ceb,
    output logic bbc_cycle,
    output logic phi0_err
);

    localparam logic [1:0] ST_LO   = 2'd0;
    localparam logic [1:0] ST_FHI  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_BHI  = 2'd3;

    localparam int CW = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(SYNC_TIMEOUT - 1);

    // Even parity over the state code; a mismatch means the state flops were upset.
    function automatic logic state_parity(input logic [1:0] st);
        return ^st;
    endfunction

    logic [1:0]    state_q, state_d;
    logic          state_par_q;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          phi0_q;
    logic          cpu_ck_phi2_q, cpu_ck_phi2_d;
    logic          ram_ceb_q, ram_ceb_d;
    logic          bbc_cycle_q, bbc_cycle_d;
    logic          phi0_err_q, phi0_err_d;

    logic valid_s;
    logic bbc_tgt_s;
    logic phi0_rise_s;
    logic phi0_fall_s;
    logic tmo_hit_s;
    logic state_ok_s;

    assign valid_s     = vda | vpa;
    assign bbc_tgt_s   = ~fast_en | addr15 | ~vpb;
    assign phi0_rise_s = bbc_ck2_phi0 & ~phi0_q;
    assign phi0_fall_s = ~bbc_ck2_phi0 & phi0_q;
    assign tmo_hit_s   = (tmo_cnt_q == TMO_LAST);
    assign state_ok_s  = (state_parity(state_q) == state_par_q);

    // Next-state, timeout counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        ram_ceb_d  = 1'b1;
        phi0_err_d = phi0_err_q;
        if (!state_ok_s) begin
            state_d   = ST_LO;
            tmo_cnt_d = '0;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (valid_s && bbc_tgt_s) begin
                        state_d   = ST_SYNC;
                        tmo_cnt_d = '0;
                    end else begin
                        state_d   = ST_FHI;
                        ram_ceb_d = ~valid_s;
                    end
                end
                ST_FHI: begin
                    state_d = ST_LO;
                end
                ST_SYNC: begin
                    if (phi0_rise_s) begin
                        state_d   = ST_BHI;
                        tmo_cnt_d = '0;
                    end else if (tmo_hit_s) begin
                        // Dummy internal cycle so the CPU never stalls on a dead phi0.
                        state_d    = ST_FHI;
                        phi0_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CW'(1);
                    end
                end
                ST_BHI: begin
                    if (phi0_fall_s) begin
                        state_d = ST_LO;
                    end else if (tmo_hit_s) begin
                        state_d    = ST_FHI;
                        phi0_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = ST_LO;
                    tmo_cnt_d = '0;
                end
            endcase
        end
        cpu_ck_phi2_d = (state_d == ST_FHI) || (state_d == ST_BHI);
        bbc_cycle_d   = (state_d == ST_BHI);
    end

    // State, phi0 history and output flops.
    always_ff @(posedge bbc_ck8 or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_LO;
            state_par_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            phi0_q        <= 1'b0;
            cpu_ck_phi2_q <= 1'b0;
            ram_ceb_q     <= 1'b1;
            bbc_cycle_q   <= 1'b0;
            phi0_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            state_par_q   <= state_parity(state_d);
            tmo_cnt_q     <= tmo_cnt_d;
            phi0_q        <= bbc_ck2_phi0;
            cpu_ck_phi2_q <= cpu_ck_phi2_d;
            ram_ceb_q     <= ram_ceb_d;
            bbc_cycle_q   <= bbc_cycle_d;
            phi0_err_q    <= phi0_err_d;
        end
    end

    assign cpu_ck_phi2 = cpu_ck_phi2_q;
    assign ram_ceb     = ram_ceb_q;
    assign bbc_cycle   = bbc_cycle_q;
    assign phi0_err    = phi0_err_q;

endmodule

// File: tb/tb_bbc_cycle_sched.sv
// Self-checking bench for bbc_cycle_sched: a look-ahead model over a pre-built phi0
// waveform predicts every output for every bbc_ck8 cycle.
`timescale 1ns/1ps
module tb_bbc_cycle_sched;

    localparam int T    = 12;
    localparam int NCYC = 2000;
    localparam int NEVER = 1000000;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic phi0 = 1'b0;
    logic fast_en = 1'b0;
    logic addr15 = 1'b0;
    logic vda = 1'b0;
    logic vpa = 1'b0;
    logic vpb = 1'b1;
    logic cpu_ck_phi2, ram_ceb, bbc_cycle, phi0_err;

    typedef struct packed {
        logic phi2;
        logic ceb;
        logic bbc;
    } exp_t;

    bit   p [0:NCYC+63];
    exp_t q [$];
    int   cyc = 0;
    int   err_from = NEVER;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bbc_cycle_sched #(.SYNC_TIMEOUT(T)) dut (
        .bbc_ck8      (clk),
        .resetb       (resetb),
        .bbc_ck2_phi0 (phi0),
        .fast_en      (fast_en),
        .addr15       (addr15),
        .vda          (vda),
        .vpa          (vpa),
        .vpb          (vpb),
        .cpu_ck_phi2  (cpu_ck_phi2),
        .ram_ceb      (ram_ceb),
        .bbc_cycle    (bbc_cycle),
        .phi0_err     (phi0_err)
    );

    function automatic exp_t mk(input logic ph, input logic ce, input logic bb);
        exp_t e;
        e.phi2 = ph;
        e.ceb  = ce;
        e.bbc  = bb;
        return e;
    endfunction

    function automatic bit rise_at(input int c);
        return p[c] && !p[c-1];
    endfunction

    function automatic bit fall_at(input int c);
        return !p[c] && p[c-1];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
        end
    endtask

    // Schedule the whole CPU cycle whose low phase is cycle t.
    task automatic plan(input int t, input bit is_valid, input bit is_bbc);
        int r;
        int f;
        if (!is_valid || !is_bbc) begin
            q.push_back(mk(1'b1, !is_valid, 1'b0));
        end else begin
            r = -1;
            for (int k = 1; k <= T; k++)
                if (r < 0 && rise_at(t + k)) r = t + k;
            if (r < 0) begin
                repeat (T) q.push_back(mk(1'b0, 1'b1, 1'b0));
                if (err_from > t + T + 1) err_from = t + T + 1;
                q.push_back(mk(1'b1, 1'b1, 1'b0));
            end else begin
                repeat (r - t) q.push_back(mk(1'b0, 1'b1, 1'b0));
                f = -1;
                for (int k = 1; k <= T; k++)
                    if (f < 0 && fall_at(r + k)) f = r + k;
                if (f < 0) begin
                    repeat (T) q.push_back(mk(1'b1, 1'b1, 1'b1));
                    if (err_from > r + T + 1) err_from = r + T + 1;
                    q.push_back(mk(1'b1, 1'b1, 1'b0));
                end else begin
                    repeat (f - r) q.push_back(mk(1'b1, 1'b1, 1'b1));
                end
            end
        end
    endtask

    task automatic cycle(input bit fe, input bit a15, input bit va, input bit vp,
                         input bit vb, input bit rb);
        exp_t e;
        @(posedge clk);
        #1;
        if (!rb && q.size() > 0) chk("pre_reset_bbc", bbc_cycle, q[0].bbc);
        phi0    = p[cyc];
        fast_en = fe;
        addr15  = a15;
        vda     = va;
        vpa     = vp;
        vpb     = vb;
        resetb  = rb;
        if (!rb) begin
            q.delete();
            err_from = NEVER;
            e = mk(1'b0, 1'b1, 1'b0);
        end else if (q.size() == 0) begin
            e = mk(1'b0, 1'b1, 1'b0);
            plan(cyc, va | vp, !fe | a15 | !vb);
        end else begin
            e = q.pop_front();
        end
        @(negedge clk);
        chk("cpu_ck_phi2", cpu_ck_phi2, e.phi2);
        chk("ram_ceb", ram_ceb, e.ceb);
        chk("bbc_cycle", bbc_cycle, e.bbc);
        chk("phi0_err", phi0_err, (cyc >= err_from) ? 1'b1 : 1'b0);
        cyc++;
    endtask

    task automatic rnd_cycles(input int n, input int fe_mode, input int rst_odds);
        bit fe;
        for (int i = 0; i < n; i++) begin
            fe = (fe_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(fe_mode);
            cycle(fe, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                  (rst_odds == 0) ? 1'b1 : ($urandom_range(0, rst_odds) != 0));
        end
    endtask

    initial begin
        int guard;
        for (int c = 0; c < $size(p); c++) begin
            if (c >= 800 && c < 850)      p[c] = 1'b0;
            else if (c >= 900 && c < 950) p[c] = 1'b1;
            else                          p[c] = ((c + 1) % 4) < 2;
        end

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // fast reads
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        // BBC accesses at every phi0 offset: idle gaps of random length shift the phase
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        // BBC-only mode, then fast_en toggling at random points
        repeat (30) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        rnd_cycles(100, 2, 0);
        // vector pull in the low 32 KB
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        while (cyc < 780) rnd_cycles(1, 2, 0);
        // continuous BBC requests across phi0 stuck-low and stuck-high windows
        while (cyc < 980) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // asynchronous reset in the middle of a BBC high phase
        guard = 0;
        while (!(q.size() > 0 && q[0].bbc) && guard < 40) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        chk("reach_bhi_in_budget", (guard < 40) ? 1'b1 : 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // random mix with occasional resets
        rnd_cycles(500, 2, 150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
